// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared constants and types for the framebuffer write path.
// Revision : 1.0  initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W      = 150;
    localparam int FB_H      = 480;
    localparam int FB_PIXELS = 72000;

    localparam logic [7:0] REG_PIXEL  = 8'd0;
    localparam logic [7:0] REG_ORIGIN = 8'd1;
    localparam logic [7:0] REG_SIZE   = 8'd2;
    localparam logic [7:0] REG_GO     = 8'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } pix_wr_t;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fb_wr_fifo
// Purpose  : Synchronous FIFO of pixel writes with full/empty flags.
// Revision : 1.0  initial release
// ============================================================================
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  pix_wr_t i_push_data,
    input  logic    i_pop,
    output pix_wr_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    pix_wr_t            r_mem [DEPTH];
    logic [c_ptr_w:0]   r_wr_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign o_head  = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : fb_wr_fifo
`default_nettype wire

// File: rtl/fb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fb_write_scheduler
// Purpose  : Arbitrates CPU pixel writes and a rectangle-fill engine onto the
//            single framebuffer write port. Build option VBLANK_GATE_EN
//            restricts memory writes to the vertical blanking interval.
// Revision : 1.0  initial release
// ============================================================================
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [7:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    input  logic              in_vblank,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [7:0]        mem_wd,
    output logic              mem_we,
    output logic              fill_done
);

    localparam logic [7:0]  c_fb_w     = 8'(FB_W);
    localparam logic [8:0]  c_fb_h     = 9'(FB_H);
    localparam logic [16:0] c_pixels   = 17'(FB_PIXELS);
    localparam logic [16:0] c_row_step = 17'(FB_W);

    fill_state_t r_state;
    fill_state_t w_state_next;

    logic        w_gate_ok;
    logic        w_wr;
    logic        w_push_acc;
    logic        w_push_ok;
    logic        w_cpu_issue;
    logic        w_fill_issue;
    logic        w_fill_last;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_push;
    logic        w_fifo_pop;
    pix_wr_t     w_fifo_head;
    pix_wr_t     w_push_pix;
    pix_wr_t     w_cpu_pix;

    logic        w_go;
    logic        w_go_clear;
    logic        w_go_start;
    logic        w_go_empty;
    logic        w_origin_ok;
    logic        w_size_ok;
    logic [7:0]  w_col_room;
    logic [8:0]  w_row_room;
    logic [7:0]  w_eff_w;
    logic [8:0]  w_eff_h;
    logic [16:0] w_row17;
    logic [16:0] w_start_base;
    logic        w_unused;

    logic [7:0]  r_org_col;
    logic [8:0]  r_org_row;
    logic [7:0]  r_size_w;
    logic [8:0]  r_size_h;
    logic [7:0]  r_eff_w;
    logic [8:0]  r_eff_h;
    logic [7:0]  r_col_cnt;
    logic [8:0]  r_row_cnt;
    logic [7:0]  r_colour;
    logic [16:0] r_base;
    logic        r_err;

`ifdef VBLANK_GATE_EN
    assign w_gate_ok = in_vblank;
    assign w_unused  = ^writedata[30:25];
`else
    assign w_gate_ok = 1'b1;
    assign w_unused  = ^{writedata[30:25], in_vblank};
`endif

    always_comb begin
        waitrequest = 1'b0;
        if (chipselect && write) begin
            if (address == REG_PIXEL) begin
                waitrequest = w_fifo_full;
            end else if (address == REG_ORIGIN || address == REG_SIZE ||
                         address == REG_GO) begin
                waitrequest = (r_state != IDLE);
            end
        end
    end

    assign w_wr       = chipselect && write && !waitrequest;
    assign w_push_pix = '{addr: writedata[24:8], data: writedata[7:0]};
    assign w_push_acc = w_wr && (address == REG_PIXEL);
    assign w_push_ok  = w_push_acc && (writedata[24:8] < c_pixels);

    // An empty FIFO is bypassed so an accepted push reaches memory next cycle.
    assign w_cpu_issue  = w_gate_ok && (!w_fifo_empty || w_push_ok);
    assign w_fifo_pop   = w_gate_ok && !w_fifo_empty;
    assign w_fifo_push  = w_push_ok && !(w_gate_ok && w_fifo_empty);
    assign w_cpu_pix    = w_fifo_empty ? w_push_pix : w_fifo_head;
    assign w_fill_issue = w_gate_ok && !w_cpu_issue && (r_state == FILL);
    assign w_fill_last  = (r_col_cnt == r_eff_w - 8'd1) &&
                          (r_row_cnt == r_eff_h - 9'd1);

    fb_wr_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .i_rst_n     (reset_n),
        .i_push      (w_fifo_push),
        .i_push_data (w_push_pix),
        .i_pop       (w_fifo_pop),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Clip the rectangle to the framebuffer; an off-screen origin means no fill.
    assign w_origin_ok = (r_org_col < c_fb_w) && (r_org_row < c_fb_h);
    assign w_col_room  = c_fb_w - r_org_col;
    assign w_row_room  = c_fb_h - r_org_row;
    assign w_eff_w     = !w_origin_ok ? 8'd0 :
                         (r_size_w < w_col_room) ? r_size_w : w_col_room;
    assign w_eff_h     = !w_origin_ok ? 9'd0 :
                         (r_size_h < w_row_room) ? r_size_h : w_row_room;
    assign w_size_ok   = (w_eff_w != 8'd0) && (w_eff_h != 9'd0);

    // row*150 as row*(128+16+4+2)
    assign w_row17      = {8'd0, r_org_row};
    assign w_start_base = (w_row17 << 7) + (w_row17 << 4) + (w_row17 << 2) +
                          (w_row17 << 1) + {9'd0, r_org_col};

    assign w_go       = w_wr && (address == REG_GO);
    assign w_go_clear = w_go && writedata[31];
    assign w_go_start = w_go && !writedata[31] && w_size_ok;
    assign w_go_empty = w_go && !writedata[31] && !w_size_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_go_start) w_state_next = FILL;
            FILL: if (w_fill_issue && w_fill_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_org_col <= '0;
            r_org_row <= '0;
            r_size_w  <= '0;
            r_size_h  <= '0;
            r_eff_w   <= '0;
            r_eff_h   <= '0;
            r_col_cnt <= '0;
            r_row_cnt <= '0;
            r_colour  <= '0;
            r_base    <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_wr && address == REG_ORIGIN) begin
                r_org_row <= writedata[24:16];
                r_org_col <= writedata[7:0];
            end
            if (w_wr && address == REG_SIZE) begin
                r_size_h <= writedata[24:16];
                r_size_w <= writedata[7:0];
            end
            if (w_go_start) begin
                r_eff_w   <= w_eff_w;
                r_eff_h   <= w_eff_h;
                r_base    <= w_start_base;
                r_col_cnt <= '0;
                r_row_cnt <= '0;
                r_colour  <= writedata[7:0];
            end else if (w_fill_issue) begin
                if (r_col_cnt == r_eff_w - 8'd1) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= r_row_cnt + 9'd1;
                    r_base    <= r_base + c_row_step;
                end else begin
                    r_col_cnt <= r_col_cnt + 8'd1;
                end
            end
            if (w_push_acc && !w_push_ok) begin
                r_err <= 1'b1;
            end else if (w_go_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_wa    <= '0;
            mem_wd    <= '0;
            fill_done <= 1'b0;
            readdata  <= '0;
        end else begin
            mem_we    <= w_cpu_issue || w_fill_issue;
            fill_done <= w_go_empty || (w_fill_issue && w_fill_last);
            if (w_cpu_issue) begin
                mem_wa <= ADDR_W'(w_cpu_pix.addr);
                mem_wd <= w_cpu_pix.data;
            end else if (w_fill_issue) begin
                mem_wa <= ADDR_W'(r_base + {9'd0, r_col_cnt});
                mem_wd <= r_colour;
            end
            if (chipselect && read) begin
                readdata <= {27'd0, r_err, w_fifo_empty, w_fifo_full,
                             (r_state != IDLE), w_unused & 1'b0};
            end
        end
    end

endmodule : fb_write_scheduler
`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_write_scheduler
// Purpose  : Directed self-checking bench for fb_write_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_fb_write_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        in_vblank = 1'b1;
    logic [16:0] mem_wa;
    logic [7:0]  mem_wd;
    logic        mem_we;
    logic        fill_done;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    logic [16:0] q_addr[$];
    logic [7:0]  q_data[$];
    logic        q_done[$];

    fb_write_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .in_vblank   (in_vblank),
        .mem_wa      (mem_wa),
        .mem_wd      (mem_wd),
        .mem_we      (mem_we),
        .fill_done   (fill_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            q_addr.push_back(mem_wa);
            q_data.push_back(mem_wd);
            q_done.push_back(fill_done);
        end
        if (reset_n && fill_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_done.delete();
    endtask

    // Entered just after a rising edge; returns #1 after the accepting edge.
    task automatic av_write(input logic [7:0] a, input logic [31:0] d, output int stall);
        stall = 0;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        #1;
        while (waitrequest && stall < 200) begin
            @(posedge clk); #1;
            stall++;
        end
        if (stall >= 200) check("write_timeout", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        chipselect = 1'b1; read = 1'b1; address = 8'd0;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        v = readdata;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int start, input int budget);
        int n = 0;
        while (done_cnt <= start && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("fill_done_seen", 32'(done_cnt > start), 32'd1);
        cycles(2);
    endtask

    initial begin
        int          st;
        int          max_stall;
        int          d0;
        logic [31:0] s;
        logic [16:0] exp_fill[9];
        int          nf;
        int          nc;

        // Reset state
        #12;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wa", 32'(mem_wa), 32'd0);
        check("rst_fill_done", 32'(fill_done), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycles(1);
        rd_status(s);
        check("status_idle", s, 32'h08);

        // Single push, visible the cycle after acceptance
        clear_log();
        av_write(8'd0, 32'h0000_0503, st);
        check("push_we", 32'(mem_we), 32'd1);
        check("push_wa", 32'(mem_wa), 32'd5);
        check("push_wd", 32'(mem_wd), 32'h03);
        cycles(1);
        check("push_we_once", 32'(mem_we), 32'd0);
        cycles(3);
        check("push_count", 32'(q_addr.size()), 32'd1);

        // Ten back-to-back pushes
        clear_log();
        max_stall = 0;
        for (int i = 0; i < 10; i++) begin
            av_write(8'd0, {7'd0, 17'(100 + 7 * i), 8'(8'h10 + i)}, st);
            if (st > max_stall) max_stall = st;
        end
        cycles(3);
        check("b2b_stall", 32'(max_stall <= 1), 32'd1);
        check("b2b_count", 32'(q_addr.size()), 32'd10);
        for (int i = 0; i < 10 && i < q_addr.size(); i++) begin
            check("b2b_addr", 32'(q_addr[i]), 32'(100 + 7 * i));
            check("b2b_data", 32'(q_data[i]), 32'(8'h10 + i));
        end

        // Clipped fill at the right edge: row 2 col 148, 2x5 -> 2x2
        clear_log();
        d0 = done_cnt;
        av_write(8'd1, {7'd0, 9'd2, 8'd0, 8'd148}, st);
        av_write(8'd2, {7'd0, 9'd2, 8'd0, 8'd5}, st);
        av_write(8'd3, 32'h02, st);
        wait_done(d0, 60);
        check("clip_count", 32'(q_addr.size()), 32'd4);
        if (q_addr.size() == 4) begin
            check("clip_a0", 32'(q_addr[0]), 32'd448);
            check("clip_a1", 32'(q_addr[1]), 32'd449);
            check("clip_a2", 32'(q_addr[2]), 32'd598);
            check("clip_a3", 32'(q_addr[3]), 32'd599);
            check("clip_data", 32'(q_data[3]), 32'h02);
            check("clip_done_early", 32'(q_done[2]), 32'd0);
            check("clip_done_last", 32'(q_done[3]), 32'd1);
        end
        check("clip_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 3x3 fill at row 10 col 20 interleaved with two CPU pushes
        clear_log();
        d0 = done_cnt;
        av_write(8'd1, {7'd0, 9'd10, 8'd0, 8'd20}, st);
        av_write(8'd2, {7'd0, 9'd3, 8'd0, 8'd3}, st);
        av_write(8'd3, 32'h55, st);
        av_write(8'd0, {7'd0, 17'd7000, 8'hAA}, st);
        check("mix_cpu0_we", 32'(mem_we), 32'd1);
        check("mix_cpu0_wa", 32'(mem_wa), 32'd7000);
        av_write(8'd0, {7'd0, 17'd7001, 8'hBB}, st);
        check("mix_cpu1_wa", 32'(mem_wa), 32'd7001);
        av_write(8'd1, {7'd0, 9'd10, 8'd0, 8'd20}, st);
        check("mix_cfg_stalled", 32'(st > 0), 32'd1);
        wait_done(d0, 60);
        exp_fill = '{17'd1520, 17'd1521, 17'd1522, 17'd1670, 17'd1671,
                     17'd1672, 17'd1820, 17'd1821, 17'd1822};
        nf = 0;
        nc = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_data[i] == 8'h55) begin
                if (nf < 9) check("mix_fill_addr", 32'(q_addr[i]), 32'(exp_fill[nf]));
                nf++;
            end else begin
                check("mix_cpu_addr", 32'(q_addr[i]), 32'(17'd7000 + 17'(nc)));
                nc++;
            end
        end
        check("mix_fill_count", 32'(nf), 32'd9);
        check("mix_cpu_count", 32'(nc), 32'd2);

        // Zero-size and off-screen fills only pulse fill_done
        clear_log();
        av_write(8'd2, {7'd0, 9'd3, 8'd0, 8'd0}, st);
        av_write(8'd3, 32'h07, st);
        check("zero_w_done", 32'(fill_done), 32'd1);
        av_write(8'd1, {7'd0, 9'd0, 8'd0, 8'd150}, st);
        av_write(8'd2, {7'd0, 9'd3, 8'd0, 8'd3}, st);
        av_write(8'd3, 32'h07, st);
        check("offscreen_done", 32'(fill_done), 32'd1);
        cycles(3);
        check("zero_no_strobe", 32'(q_addr.size()), 32'd0);
        rd_status(s);
        check("zero_not_busy", s, 32'h08);

        // Last valid address and first invalid one
        clear_log();
        av_write(8'd0, {7'd0, 17'd71999, 8'h44}, st);
        check("edge_ok_wa", 32'(mem_wa), 32'd71999);
        av_write(8'd0, {7'd0, 17'd72000, 8'h11}, st);
        cycles(3);
        check("oob_count", 32'(q_addr.size()), 32'd1);
        rd_status(s);
        check("oob_err", s, 32'h18);
        d0 = done_cnt;
        av_write(8'd3, 32'h8000_0000, st);
        cycles(3);
        rd_status(s);
        check("err_cleared", s, 32'h08);
        check("clear_no_fill", 32'(done_cnt - d0), 32'd0);
        check("clear_no_strobe", 32'(q_addr.size()), 32'd1);

`ifdef VBLANK_GATE_EN
        // Gated build: writes hold off until vblank
        clear_log();
        in_vblank = 1'b0;
        for (int i = 0; i < 8; i++) av_write(8'd0, {7'd0, 17'(200 + i), 8'(i)}, st);
        chipselect = 1'b1; write = 1'b1; address = 8'd0;
        writedata = {7'd0, 17'd208, 8'd8};
        cycles(4);
        check("vb_full_wait", 32'(waitrequest), 32'd1);
        check("vb_no_strobe", 32'(q_addr.size()), 32'd0);
        in_vblank = 1'b1;
        #1;
        st = 0;
        while (waitrequest && st < 20) begin @(posedge clk); #1; st++; end
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
        cycles(12);
        check("vb_drain_count", 32'(q_addr.size()), 32'd9);
        for (int i = 0; i < 9 && i < q_addr.size(); i++)
            check("vb_drain_addr", 32'(q_addr[i]), 32'(200 + i));
        in_vblank = 1'b0;
        for (int i = 0; i < 4; i++) av_write(8'd0, {7'd0, 17'(300 + i), 8'(i)}, st);
        in_vblank = 1'b1;
        cycles(1);
        reset_n = 1'b0;
        #1;
        check("vb_rst_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycles(1);
        rd_status(s);
        check("vb_rst_empty", s, 32'h08);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fb_write_scheduler
`default_nettype wire

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sequences all writes into the 150x480, 8-bit-per-pixel lane framebuffer memory (72,000 entries, 17-bit address, address = row*150 + col).
- Arbitrates one memory write port between two requesters:
  - Avalon CPU pixel writes, buffered in a FIFO.
  - A hardware rectangle-fill engine that clears and colours lanes and notes.
- Sits between the Avalon slave interface and the framebuffer's single write port; the framebuffer read side is untouched.

Parameters:
- FB_W, 150, framebuffer width in pixels.
- FB_H, 480, framebuffer height in pixels.
- ADDR_W, 17, memory address width.
- FIFO_DEPTH, 8, CPU write FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe.
- read  in  1  Avalon read strobe.
- address  in  8  Avalon register index.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data (status).
- waitrequest  out  1  Avalon stall; the write is not accepted while high.
- in_vblank  in  1  high outside active video (from the VGA counters).
- mem_wa  out  17  framebuffer write address.
- mem_wd  out  8  framebuffer write data.
- mem_we  out  1  framebuffer write enable, one-cycle strobe per pixel.
- fill_done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (async, reset_n low): all outputs 0; FIFO empty; fill FSM IDLE; rect registers 0; err sticky flag 0.
- Register map (write):
  - addr 0 = pixel push, {7'b0, pix_addr[16:0], data[7:0]}.
  - addr 1 = fill origin, {row[24:16] (9b), col[7:0]}.
  - addr 2 = fill size, {h[24:16] (9b), w[7:0]}.
  - addr 3 = fill go, colour = data[7:0].
  - Other addresses are ignored.
- Register map (read, any address): readdata = {27'b0, err, fifo_empty, fifo_full, fill_busy, 1'b0}, registered, valid the cycle after read.
- waitrequest:
  - addr 0: high when FIFO full.
  - addr 1-3: high while fill FSM != IDLE.
  - Otherwise 0. Combinational from state, not from writedata.
- Pixel push with pix_addr >= 72000: accepted, dropped, err set sticky. err clears on a write to addr 3 with writedata[31]=1; that write starts no fill.
- Arbitration: CPU FIFO has strict priority. The fill engine issues only in cycles where the FIFO is empty or gated. At most one mem_we per cycle.
- Latency: a push accepted at edge N into an empty FIFO drives mem_we/mem_wa/mem_wd (registered) during cycle N+1. Write order within the FIFO is preserved.
- FIFO:
  - Simultaneous push and pop when not full: both occur, level unchanged.
  - Push while full: impossible, because waitrequest holds it off.
- Fill FSM:
  - IDLE -> FILL on go when w!=0 and h!=0.
  - Go with w==0 or h==0: fill_done pulses the next cycle; FSM stays IDLE.
  - FILL: row-major walk. Address is a row base (start = row0*150 + col0, computed once via shift-add) plus a column offset; the base advances by +150 per row, with no per-pixel multiplier.
  - Clipping: effective w = min(w, 150-col0), h = min(h, 480-row0). Origin out of range (col0>=150 or row0>=480): treated as zero size.
  - After the last pixel's mem_we: FILL -> IDLE, with fill_done the same cycle as that final mem_we.
- Reset mid-fill or with the FIFO non-empty: everything is abandoned immediately. No partial strobe; mem_we drops asynchronously.

Optional Feature:
- Macro VBLANK_GATE_EN.
- Defined: mem_we is asserted only while in_vblank=1; FIFO pops and fill steps stall otherwise, so waitrequest backs up naturally. This gives tear-free updates.
- Undefined: in_vblank is ignored and writes issue every available cycle.

Decomposition:
- Package fb_pkg holds:
  - FB_W, FB_H, FB_PIXELS=72000.
  - Register index constants REG_PIXEL=0, REG_ORIGIN=1, REG_SIZE=2, REG_GO=3.
  - typedef fill_state_t {IDLE, FILL}.
  - typedef pix_wr_t {logic [16:0] addr; logic [7:0] data;}.
- Sub-module fb_wr_fifo: synchronous FIFO of pix_wr_t with full/empty, parameterised by depth.

Test Plan:
- Reset: write addr0=0x0000_0503 -> mem_we=1, mem_wa=5, mem_wd=0x03 in the next cycle; no further strobes.
- Back-to-back 10 pushes with no gating -> waitrequest is never high for more than a cycle; 10 strobes occur, in order, with matching addr/data.
- Fill origin row=2 col=148, size h=2 w=5, colour 0x02 -> exactly 4 strobes at addresses 448, 449, 598, 599. fill_done coincides with the 599 strobe.
- Fill of 3x3 running while 2 CPU pushes arrive -> CPU strobes appear the cycle after acceptance; the fill pauses and resumes. 9 fill strobes total; addr1-3 writes stall during the fill.
- Push pix_addr=72000 -> no strobe, status err=1; clear write (addr 3, bit31=1) -> err=0, no fill.
- VBLANK_GATE_EN defined, in_vblank=0, push 9 entries -> 9th waitrequest stays high and no mem_we; raise in_vblank -> 9 strobes drain in order. Reset mid-drain -> mem_we=0 immediately and status shows fifo_empty.
